// File: rtl/main_ram_arbiter_pkg.sv
// main_ram_arbiter_pkg: shared widths, port indices and one-hot grant encodings for the main RAM arbiter.
package main_ram_arbiter_pkg;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int BSEL_W = DATA_W / 8;
    localparam int ARB_P0 = 0;
    localparam int ARB_P1 = 1;
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_P0   = 2'b01,
        GNT_P1   = 2'b10
    } grant_t;
endpackage

// File: rtl/main_ram_arbiter_if.sv
// main_ram_arbiter_if: both requester ports plus the RAM bus; slave is the arbiter view, master the requester/RAM view.
interface main_ram_arbiter_if;
    import main_ram_arbiter_pkg::*;
    logic              p0_strobe, p1_strobe;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wrdata, p1_wrdata;
    logic [BSEL_W-1:0] p0_wrbytesel, p1_wrbytesel;
    logic              p0_write, p1_write;
    logic              p0_ack, p1_ack;
    logic [DATA_W-1:0] p0_rddata, p1_rddata;
    logic              p0_rdvalid, p1_rdvalid;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wrdata;
    logic [BSEL_W-1:0] bus_wrbytesel;
    logic              bus_write;
    logic [DATA_W-1:0] bus_rddata;
    modport slave (
        input  p0_strobe, p0_addr, p0_wrdata, p0_wrbytesel, p0_write,
        input  p1_strobe, p1_addr, p1_wrdata, p1_wrbytesel, p1_write,
        output p0_ack, p0_rddata, p0_rdvalid, p1_ack, p1_rddata, p1_rdvalid,
        output bus_addr, bus_wrdata, bus_wrbytesel, bus_write,
        input  bus_rddata
    );
    modport master (
        output p0_strobe, p0_addr, p0_wrdata, p0_wrbytesel, p0_write,
        output p1_strobe, p1_addr, p1_wrdata, p1_wrbytesel, p1_write,
        input  p0_ack, p0_rddata, p0_rdvalid, p1_ack, p1_rddata, p1_rdvalid,
        input  bus_addr, bus_wrdata, bus_wrbytesel, bus_write,
        output bus_rddata
    );
endinterface

// File: rtl/main_ram_arb_grant.sv
// main_ram_arb_grant: strobes + last-grant pointer -> one-hot grant and pointer next-state.
// MAIN_RAM_ARB_RR_EN selects round-robin on conflict; otherwise port 0 has fixed priority.
module main_ram_arb_grant
    import main_ram_arbiter_pkg::*;
(
    input  logic [1:0] strobe,
    input  logic       ptr,
    output grant_t     grant,
    output logic       ptr_next
);
    always_comb begin
`ifdef MAIN_RAM_ARB_RR_EN
        grant = &strobe ? (ptr ? GNT_P0 : GNT_P1) : grant_t'(strobe);
`else
        grant = strobe[ARB_P0] ? GNT_P0 : strobe[ARB_P1] ? GNT_P1 : GNT_NONE;
`endif
        // pointer remembers the last granted port, uncontested grants included
        ptr_next = (grant == GNT_NONE) ? ptr : grant[ARB_P1];
    end
endmodule

// File: rtl/main_ram_arbiter.sv
// main_ram_arbiter: two-port arbiter in front of the main RAM; bus mux, 1-cycle read tag, ack/rdvalid.
// Build option MAIN_RAM_ARB_RR_EN enables round-robin conflict resolution (default: port 0 priority).
module main_ram_arbiter
    import main_ram_arbiter_pkg::*;
(
    input logic               clk,
    input logic               rst,
    main_ram_arbiter_if.slave arb
);
    grant_t     grant_raw;
    logic [1:0] grant, rd_tag;
    logic       ptr, ptr_next;

    main_ram_arb_grant u_grant (
        .strobe   ({arb.p1_strobe, arb.p0_strobe}),
        .ptr      (ptr),
        .grant    (grant_raw),
        .ptr_next (ptr_next)
    );

    assign grant = rst ? GNT_NONE : grant_raw;
    assign arb.p0_ack = grant[ARB_P0];
    assign arb.p1_ack = grant[ARB_P1];
    assign arb.bus_addr = grant[ARB_P1] ? arb.p1_addr : arb.p0_addr;
    assign arb.bus_wrdata = grant[ARB_P1] ? arb.p1_wrdata : arb.p0_wrdata;
    assign arb.bus_wrbytesel = grant[ARB_P1] ? arb.p1_wrbytesel : arb.p0_wrbytesel;
    assign arb.bus_write = grant[ARB_P1] ? arb.p1_write : grant[ARB_P0] & arb.p0_write;

    // reset parks the pointer on port 1 so port 0 wins the first conflict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_tag <= 2'b00;
            ptr    <= 1'b1;
        end else begin
            rd_tag <= grant & ~{arb.p1_write, arb.p0_write};
            ptr    <= ptr_next;
        end
    end

    assign arb.p0_rdvalid = rd_tag[ARB_P0];
    assign arb.p1_rdvalid = rd_tag[ARB_P1];
    assign arb.p0_rddata = arb.bus_rddata;
    assign arb.p1_rddata = arb.bus_rddata;
endmodule

// File: tb/tb_main_ram_arbiter.sv
// tb_main_ram_arbiter: directed scenarios plus randomized traffic against a memory/arbitration reference model.
module tb_main_ram_arbiter;
    import main_ram_arbiter_pkg::*;
`ifdef MAIN_RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    main_ram_arbiter_if arb();
    main_ram_arbiter dut (.clk(clk), .rst(rst), .arb(arb));

    // RAM behaviour: registered read, byte-lane writes landing at the clock edge
    logic [31:0] mem [0:32767];
    always @(posedge clk) begin
        arb.bus_rddata <= mem[arb.bus_addr];
        if (arb.bus_write)
            for (int b = 0; b < 4; b++)
                if (arb.bus_wrbytesel[b]) mem[arb.bus_addr][8*b +: 8] <= arb.bus_wrdata[8*b +: 8];
    end

    logic [14:0] r_addr [2];
    logic [31:0] r_data [2];
    logic [3:0]  r_bs [2];
    logic        r_wr [2];
    logic [1:0]  pend;
    logic [31:0] ref_mem [logic [14:0]];

    function automatic logic [31:0] ref_rd(input logic [14:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic apply();
        arb.p0_strobe = pend[0]; arb.p0_addr = r_addr[0]; arb.p0_wrdata = r_data[0];
        arb.p0_wrbytesel = r_bs[0]; arb.p0_write = r_wr[0];
        arb.p1_strobe = pend[1]; arb.p1_addr = r_addr[1]; arb.p1_wrdata = r_data[1];
        arb.p1_wrbytesel = r_bs[1]; arb.p1_write = r_wr[1];
    endtask

    task automatic set_req(input int p, input logic [14:0] a, input logic [31:0] d, input logic [3:0] bs, input logic wr);
        r_addr[p] = a; r_data[p] = d; r_bs[p] = bs; r_wr[p] = wr; pend[p] = 1'b1;
        apply();
    endtask

    task automatic idle();
        pend = 2'b00;
        apply();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        pend = 2'b00;
        set_req(0, 15'h7FFF, 32'h0, 4'h0, 1'b1);
        set_req(1, 15'h7FFE, 32'h0, 4'hF, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if ({arb.p1_ack, arb.p0_ack} !== 2'b00) begin errors++; $display("FAIL rst_ack: got %b expected 00", {arb.p1_ack, arb.p0_ack}); end
            checks++; if ({arb.p1_rdvalid, arb.p0_rdvalid} !== 2'b00) begin errors++; $display("FAIL rst_rdvalid: got %b expected 00", {arb.p1_rdvalid, arb.p0_rdvalid}); end
            checks++; if (arb.bus_write !== 1'b0) begin errors++; $display("FAIL rst_bus_write: got %b expected 0", arb.bus_write); end
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({arb.p1_ack, arb.p0_ack} !== 2'b01) begin errors++; $display("FAIL rst_release_ack: got %b expected 01", {arb.p1_ack, arb.p0_ack}); end
        checks++; if ({arb.bus_write, arb.bus_wrbytesel} !== 5'b1_0000) begin errors++; $display("FAIL noop_write: got %b expected 10000", {arb.bus_write, arb.bus_wrbytesel}); end
        tick();
        idle();
        tick();
    endtask

    task automatic test_write_read();
        set_req(1, 15'h4001, 32'hDEADBEEF, 4'hF, 1'b1);
        @(negedge clk);
        checks++; if ({arb.p1_ack, arb.p0_ack} !== 2'b10) begin errors++; $display("FAIL wr_ack: got %b expected 10", {arb.p1_ack, arb.p0_ack}); end
        checks++; if ({arb.bus_write, arb.bus_addr, arb.bus_wrdata} !== {1'b1, 15'h4001, 32'hDEADBEEF}) begin
            errors++; $display("FAIL wr_bus: got %h/%h/%h expected 1/4001/deadbeef", arb.bus_write, arb.bus_addr, arb.bus_wrdata); end
        tick();
        set_req(1, 15'h4001, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        checks++; if (arb.p1_ack !== 1'b1) begin errors++; $display("FAIL rd_ack: got %b expected 1", arb.p1_ack); end
        checks++; if ({arb.bus_write, arb.p1_rdvalid} !== 2'b00) begin errors++; $display("FAIL wr_no_rdvalid: got %b expected 00", {arb.bus_write, arb.p1_rdvalid}); end
        tick();
        idle();
        @(negedge clk);
        checks++; if ({arb.p1_rdvalid, arb.p0_rdvalid} !== 2'b10) begin errors++; $display("FAIL rd_valid: got %b expected 10", {arb.p1_rdvalid, arb.p0_rdvalid}); end
        checks++; if (arb.p1_rddata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", arb.p1_rddata); end
        tick();
    endtask

    task automatic test_byte_lanes();
        set_req(0, 15'h0123, 32'h11223344, 4'b1111, 1'b1);
        tick();
        set_req(0, 15'h0123, 32'hAABBCCDD, 4'b0101, 1'b1);
        @(negedge clk);
        checks++; if ({arb.p0_ack, arb.bus_wrbytesel} !== 5'b1_0101) begin errors++; $display("FAIL bl_bytesel: got %b expected 10101", {arb.p0_ack, arb.bus_wrbytesel}); end
        tick();
        set_req(0, 15'h0123, 32'h0, 4'h0, 1'b0);
        tick();
        idle();
        @(negedge clk);
        checks++; if ({arb.p0_rdvalid, arb.p0_rddata} !== {1'b1, 32'h11BB33DD}) begin
            errors++; $display("FAIL bl_data: got %b/%h expected 1/11bb33dd", arb.p0_rdvalid, arb.p0_rddata); end
        tick();
    endtask

    task automatic test_conflict();
        int n0, n1;
        logic [1:0] exp;
        n0 = 0; n1 = 0;
        set_req(1, 15'h7FFE, 32'h0, 4'hF, 1'b0);
        tick();
        set_req(0, 15'h0000, 32'h0, 4'hF, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp = (RR && c % 2 == 1) ? 2'b10 : 2'b01;
            checks++; if ({arb.p1_ack, arb.p0_ack} !== exp) begin errors++; $display("FAIL conflict_c%0d: got %b expected %b", c, {arb.p1_ack, arb.p0_ack}, exp); end
            n0 += int'(arb.p0_ack);
            n1 += int'(arb.p1_ack);
            tick();
        end
        checks++; if (n0 !== (RR ? 2 : 4) || n1 !== (RR ? 2 : 0)) begin errors++; $display("FAIL conflict_count: got %0d/%0d expected %0d/%0d", n0, n1, RR ? 2 : 4, RR ? 2 : 0); end
        idle();
        tick();
    endtask

    task automatic test_bank_split();
        set_req(1, 15'h0010, 32'hA5A50010, 4'hF, 1'b1);
        tick();
        set_req(1, 15'h4010, 32'h5A5A4010, 4'hF, 1'b1);
        tick();
        pend = 2'b00;
        set_req(0, 15'h0010, 32'h0, 4'hF, 1'b0);
        tick();
        set_req(0, 15'h4010, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        checks++; if ({arb.p0_ack, arb.p0_rdvalid, arb.p0_rddata} !== {2'b11, 32'hA5A50010}) begin
            errors++; $display("FAIL bank_lo: got %b%b/%h expected 11/a5a50010", arb.p0_ack, arb.p0_rdvalid, arb.p0_rddata); end
        tick();
        idle();
        @(negedge clk);
        checks++; if ({arb.p0_rdvalid, arb.p0_rddata} !== {1'b1, 32'h5A5A4010}) begin
            errors++; $display("FAIL bank_hi: got %b/%h expected 1/5a5a4010", arb.p0_rdvalid, arb.p0_rddata); end
        tick();
        @(negedge clk);
        checks++; if (arb.p0_rdvalid !== 1'b0) begin errors++; $display("FAIL bank_drain: got %b expected 0", arb.p0_rdvalid); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        set_req(0, 15'h4001, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        checks++; if (arb.p0_ack !== 1'b1) begin errors++; $display("FAIL mid_ack: got %b expected 1", arb.p0_ack); end
        rst = 1'b1;
        idle();
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin tick(); rst = 1'b0; end
            @(negedge clk);
            checks++; if ({arb.p1_rdvalid, arb.p0_rdvalid} !== 2'b00) begin errors++; $display("FAIL mid_rdvalid_c%0d: got %b expected 00", c, {arb.p1_rdvalid, arb.p0_rdvalid}); end
        end
        tick();
    endtask

    task automatic test_random();
        logic [1:0]  g, exp_v;
        logic [31:0] exp_d [2];
        logic        last;
        int          p;
        pend = 2'b00;
        set_req(0, 15'h0200, 32'h0, 4'h0, 1'b1);
        tick();
        last = 1'b0;
        exp_v = 2'b00;
        idle();
        for (int c = 0; c < 400; c++) begin
            for (int q = 0; q < 2; q++)
                if (!pend[q] && $urandom_range(0, 1) == 1) begin
                    r_addr[q] = ($urandom_range(0, 1) == 1 ? 15'h4200 : 15'h0200) + 15'($urandom_range(0, 3));
                    r_data[q] = $urandom;
                    r_bs[q] = 4'($urandom);
                    r_wr[q] = 1'($urandom);
                    pend[q] = 1'b1;
                end
            apply();
            @(negedge clk);
            for (int q = 0; q < 2; q++) begin
                checks++; if ((q == 0 ? arb.p0_rdvalid : arb.p1_rdvalid) !== exp_v[q]) begin
                    errors++; $display("FAIL rnd_rdvalid p%0d c%0d: got %b expected %b", q, c, q == 0 ? arb.p0_rdvalid : arb.p1_rdvalid, exp_v[q]); end
                if (exp_v[q]) begin
                    checks++; if ((q == 0 ? arb.p0_rddata : arb.p1_rddata) !== exp_d[q]) begin
                        errors++; $display("FAIL rnd_rddata p%0d c%0d: got %h expected %h", q, c, q == 0 ? arb.p0_rddata : arb.p1_rddata, exp_d[q]); end
                end
            end
            g = pend == 2'b11 ? (RR ? (last ? 2'b01 : 2'b10) : 2'b01) : pend;
            checks++; if ({arb.p1_ack, arb.p0_ack} !== g) begin errors++; $display("FAIL rnd_ack c%0d: got %b expected %b", c, {arb.p1_ack, arb.p0_ack}, g); end
            exp_v = 2'b00;
            if (g != 2'b00) begin
                p = g[1] ? 1 : 0;
                checks++; if ({arb.bus_write, arb.bus_addr} !== {r_wr[p], r_addr[p]}) begin
                    errors++; $display("FAIL rnd_bus c%0d: got %b/%h expected %b/%h", c, arb.bus_write, arb.bus_addr, r_wr[p], r_addr[p]); end
                if (r_wr[p]) begin
                    logic [31:0] v;
                    v = ref_rd(r_addr[p]);
                    for (int b = 0; b < 4; b++) if (r_bs[p][b]) v[8*b +: 8] = r_data[p][8*b +: 8];
                    ref_mem[r_addr[p]] = v;
                end else begin
                    exp_v[p] = 1'b1;
                    exp_d[p] = ref_rd(r_addr[p]);
                end
                last = g[1];
            end
            pend = pend & ~g;
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
        r_addr = '{default: '0}; r_data = '{default: '0}; r_bs = '{default: '0}; r_wr = '{default: 1'b0};
        pend = 2'b00;
        apply();
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_conflict();
        test_bank_split();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
